// File: rtl/reg_writeback_if.sv
// Signal bundle between the pipeline/MDU/hazard logic and the register-file write-back arbiter.
// The slave side is the arbiter; the master side drives results and observes the write port.
interface reg_writeback_if;
   logic        pipe_valid;
   logic        pipe_ready;
   logic [4:0]  pipe_addr;
   logic [31:0] pipe_data;
   logic        issue_valid;
   logic [4:0]  issue_addr;
   logic        mdu_valid;
   logic        mdu_ready;
   logic [4:0]  mdu_addr;
   logic [31:0] mdu_data;
   logic        r3_wr;
   logic [4:0]  r3_addr;
   logic [31:0] r3_din;
   logic [31:0] busy;

   modport slave (
      input  pipe_valid, pipe_addr, pipe_data,
      input  issue_valid, issue_addr,
      input  mdu_valid, mdu_addr, mdu_data,
      output pipe_ready, mdu_ready,
      output r3_wr, r3_addr, r3_din, busy
   );

   modport master (
      output pipe_valid, pipe_addr, pipe_data,
      output issue_valid, issue_addr,
      output mdu_valid, mdu_addr, mdu_data,
      input  pipe_ready, mdu_ready,
      input  r3_wr, r3_addr, r3_din, busy
   );
endinterface

// File: rtl/reg_writeback.sv
// Write-back arbiter for the single register-file write port: pipeline results first, MDU results
// buffered in a FIFO, with a starvation counter and a busy scoreboard for outstanding MDU writes.
module reg_writeback #(
   parameter int FIFO_DEPTH   = 2,
   parameter int STARVE_LIMIT = 4
) (
   input logic        clk,
   input logic        rst_n,
   reg_writeback_if.slave wb
);
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   logic [4:0]    fifo_addr [FIFO_DEPTH];
   logic [31:0]   fifo_data [FIFO_DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic [SW-1:0] starve_cnt;

   logic          r3_wr_q;
   logic [4:0]    r3_addr_q;
   logic [31:0]   r3_din_q;
   logic [31:0]   busy_q;
   logic [31:0]   busy_next;

   logic          pipe_ready;
   logic          mdu_ready;
   logic          pipe_write;
   logic          push;
   logic          pop;
   logic [4:0]    head_addr;
   logic [31:0]   head_data;

   assign pipe_ready = (starve_cnt < SW'(STARVE_LIMIT));
   assign mdu_ready  = (count < CW'(FIFO_DEPTH));
   assign pipe_write = wb.pipe_valid && pipe_ready && (wb.pipe_addr != 5'd0);
   assign push       = wb.mdu_valid && mdu_ready;
   assign pop        = (count != '0) && !pipe_write;
   assign head_addr  = fifo_addr[rd_ptr];
   assign head_data  = fifo_data[rd_ptr];

   assign wb.pipe_ready = pipe_ready;
   assign wb.mdu_ready  = mdu_ready;
   assign wb.r3_wr      = r3_wr_q;
   assign wb.r3_addr    = r3_addr_q;
   assign wb.r3_din     = r3_din_q;
   assign wb.busy       = busy_q;

   // A new issue to the same register outranks the retiring write, so set is applied last.
   always_comb begin
      busy_next = busy_q;
      if (pop && (head_addr != 5'd0))
         busy_next[head_addr] = 1'b0;
      if (wb.issue_valid && (wb.issue_addr != 5'd0))
         busy_next[wb.issue_addr] = 1'b1;
      busy_next[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr[wr_ptr] <= wb.mdu_addr;
         fifo_data[wr_ptr] <= wb.mdu_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         starve_cnt <= '0;
         r3_wr_q    <= 1'b0;
         r3_addr_q  <= 5'd0;
         r3_din_q   <= 32'd0;
         busy_q     <= 32'd0;
      end else begin
         if (pipe_write) begin
            r3_wr_q   <= 1'b1;
            r3_addr_q <= wb.pipe_addr;
            r3_din_q  <= wb.pipe_data;
         end else if (pop) begin
            r3_wr_q <= (head_addr != 5'd0);
            if (head_addr != 5'd0) begin
               r3_addr_q <= head_addr;
               r3_din_q  <= head_data;
            end
         end else begin
            r3_wr_q <= 1'b0;
         end

         if (push)
            wr_ptr <= wr_ptr + PW'(1);
         if (pop)
            rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(push) - CW'(pop);

         // Saturation at the limit withholds pipe_ready, which guarantees the next edge pops.
         if ((count == '0) || pop)
            starve_cnt <= '0;
         else if (starve_cnt < SW'(STARVE_LIMIT))
            starve_cnt <= starve_cnt + SW'(1);

         busy_q <= busy_next;
      end
   end
endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback: pipeline writes, MDU buffering, starvation back-pressure,
// scoreboard set/clear races and asynchronous reset with a full FIFO.
module tb_reg_writeback;
   logic clk;
   logic rst_n;
   int   nChecks;
   int   nFails;

   reg_writeback_if wb ();

   reg_writeback #(.FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .wb    (wb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      nChecks++;
      assert (observed === expected)
      else begin
         nFails++;
         $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkWrite(input string tag, input logic [4:0] addr, input logic [31:0] data);
      check({tag, ".wr"}, 32'(wb.r3_wr), 32'd1);
      check({tag, ".addr"}, 32'(wb.r3_addr), 32'(addr));
      check({tag, ".din"}, wb.r3_din, data);
   endtask

   initial begin
      nChecks = 0;
      nFails  = 0;
      rst_n = 1'b0;
      wb.pipe_valid = 1'b0; wb.pipe_addr = 5'd0; wb.pipe_data = 32'd0;
      wb.issue_valid = 1'b0; wb.issue_addr = 5'd0;
      wb.mdu_valid = 1'b0; wb.mdu_addr = 5'd0; wb.mdu_data = 32'd0;

      #12;
      check("rst.wr", 32'(wb.r3_wr), 32'd0);
      check("rst.addr", 32'(wb.r3_addr), 32'd0);
      check("rst.din", wb.r3_din, 32'd0);
      check("rst.busy", wb.busy, 32'd0);
      check("rst.mdu_ready", 32'(wb.mdu_ready), 32'd1);
      check("rst.pipe_ready", 32'(wb.pipe_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Single pipeline write
      wb.pipe_valid = 1'b1; wb.pipe_addr = 5'd5; wb.pipe_data = 32'h1234;
      tick();
      wb.pipe_valid = 1'b0;
      checkWrite("pipe", 5'd5, 32'h1234);
      tick();
      check("pipe.idle", 32'(wb.r3_wr), 32'd0);
      check("pipe.hold", 32'(wb.r3_addr), 32'd5);

      // Issue then MDU result to r7
      wb.issue_valid = 1'b1; wb.issue_addr = 5'd7;
      tick();
      wb.issue_valid = 1'b0;
      check("issue.busy", wb.busy, 32'h0000_0080);
      wb.mdu_valid = 1'b1; wb.mdu_addr = 5'd7; wb.mdu_data = 32'hCAFE;
      tick();
      wb.mdu_valid = 1'b0;
      check("mdu.push.wr", 32'(wb.r3_wr), 32'd0);
      check("mdu.push.busy", wb.busy, 32'h0000_0080);
      tick();
      checkWrite("mdu.pop", 5'd7, 32'hCAFE);
      check("mdu.pop.busy", wb.busy, 32'd0);
      tick();
      check("mdu.idle", 32'(wb.r3_wr), 32'd0);

      // Starvation: pipeline writes every cycle while two MDU results wait
      wb.pipe_valid = 1'b1; wb.pipe_addr = 5'd1; wb.pipe_data = 32'h100;
      wb.mdu_valid = 1'b1; wb.mdu_addr = 5'd10; wb.mdu_data = 32'hA;
      tick();
      checkWrite("starve.e1", 5'd1, 32'h100);
      wb.pipe_data = 32'h101;
      wb.mdu_addr = 5'd11; wb.mdu_data = 32'hB;
      tick();
      wb.mdu_valid = 1'b0;
      checkWrite("starve.e2", 5'd1, 32'h101);
      check("starve.full", 32'(wb.mdu_ready), 32'd0);
      check("starve.e2.pready", 32'(wb.pipe_ready), 32'd1);
      wb.pipe_data = 32'h102;
      tick();
      wb.pipe_data = 32'h103;
      tick();
      check("starve.e4.pready", 32'(wb.pipe_ready), 32'd1);
      wb.pipe_data = 32'h104;
      tick();
      checkWrite("starve.e5", 5'd1, 32'h104);
      check("starve.e5.pready", 32'(wb.pipe_ready), 32'd0);
      check("starve.e5.full", 32'(wb.mdu_ready), 32'd0);
      wb.pipe_data = 32'h105;
      tick();
      checkWrite("starve.pop", 5'd10, 32'hA);
      check("starve.pop.pready", 32'(wb.pipe_ready), 32'd1);
      check("starve.pop.mready", 32'(wb.mdu_ready), 32'd1);
      tick();
      wb.pipe_valid = 1'b0;
      checkWrite("starve.e7", 5'd1, 32'h105);
      tick();
      checkWrite("starve.popB", 5'd11, 32'hB);

      // Pipeline result to r0 yields the slot to the FIFO head
      wb.mdu_valid = 1'b1; wb.mdu_addr = 5'd3; wb.mdu_data = 32'd9;
      wb.pipe_valid = 1'b0;
      tick();
      wb.mdu_valid = 1'b0;
      wb.pipe_valid = 1'b1; wb.pipe_addr = 5'd0; wb.pipe_data = 32'hDEAD;
      check("r0.pready", 32'(wb.pipe_ready), 32'd1);
      tick();
      wb.pipe_valid = 1'b0;
      checkWrite("r0.pop", 5'd3, 32'd9);
      tick();
      check("r0.idle", 32'(wb.r3_wr), 32'd0);

      // Issue to r4 on the same edge its earlier result pops: set wins
      wb.issue_valid = 1'b1; wb.issue_addr = 5'd4;
      tick();
      wb.issue_valid = 1'b0;
      wb.mdu_valid = 1'b1; wb.mdu_addr = 5'd4; wb.mdu_data = 32'h44;
      tick();
      wb.mdu_valid = 1'b0;
      wb.issue_valid = 1'b1; wb.issue_addr = 5'd4;
      tick();
      wb.issue_valid = 1'b0;
      checkWrite("race.pop", 5'd4, 32'h44);
      check("race.busy", wb.busy, 32'h0000_0010);

      // MDU result to r0 is buffered then dropped
      wb.mdu_valid = 1'b1; wb.mdu_addr = 5'd0; wb.mdu_data = 32'h55;
      tick();
      wb.mdu_valid = 1'b0;
      tick();
      check("mdu0.wr", 32'(wb.r3_wr), 32'd0);
      check("mdu0.busy", wb.busy, 32'h0000_0010);

      // Fill the FIFO, then reset asynchronously mid-cycle
      wb.pipe_valid = 1'b1; wb.pipe_addr = 5'd2; wb.pipe_data = 32'h200;
      wb.mdu_valid = 1'b1; wb.mdu_addr = 5'd20; wb.mdu_data = 32'h2020;
      wb.issue_valid = 1'b1; wb.issue_addr = 5'd20;
      tick();
      wb.issue_valid = 1'b0;
      wb.mdu_addr = 5'd21; wb.mdu_data = 32'h2121;
      tick();
      wb.mdu_valid = 1'b0;
      wb.pipe_valid = 1'b0;
      check("full.mready", 32'(wb.mdu_ready), 32'd0);
      check("full.busy", wb.busy, 32'h0010_0010);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst.wr", 32'(wb.r3_wr), 32'd0);
      check("arst.addr", 32'(wb.r3_addr), 32'd0);
      check("arst.din", wb.r3_din, 32'd0);
      check("arst.busy", wb.busy, 32'd0);
      check("arst.mready", 32'(wb.mdu_ready), 32'd1);
      check("arst.pready", 32'(wb.pipe_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("post.wr1", 32'(wb.r3_wr), 32'd0);
      tick();
      check("post.wr2", 32'(wb.r3_wr), 32'd0);
      check("post.mready", 32'(wb.mdu_ready), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end
endmodule
